rx_pkt_fifo: RTL



---
 rtl/rx_fifo_pkg.sv | 32 +++
 rtl/rx_pkt_fifo_ram.sv | 25 ++
 rtl/rx_pkt_fifo.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/rx_fifo_pkg.sv
// Shared definitions for the rx_pkt_fifo store-and-forward RX FIFO:
// write-FSM state encodings, entry layout helpers and mod-width derivation.
package rx_fifo_pkg;

  typedef logic [1:0] wr_state_t;

  localparam wr_state_t IDLE = 2'd0;
  localparam wr_state_t PKT  = 2'd1;
  localparam wr_state_t DROP = 2'd2;

  function automatic int mod_width(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  // Entry layout, LSB first: data, eop, sop, mod
  function automatic int entry_width(input int data_w, input int mod_w);
    return data_w + mod_w + 2;
  endfunction

  function automatic int eop_pos(input int data_w);
    return data_w;
  endfunction

  function automatic int sop_pos(input int data_w);
    return data_w + 1;
  endfunction

  function automatic int mod_lsb(input int data_w);
    return data_w + 2;
  endfunction

endpackage

// File: rtl/rx_pkt_fifo_ram.sv
// Simple dual-port inferred RAM with a registered read port; the read
// register holds its value whenever re is low.
module rx_pkt_fifo_ram
  import rx_fifo_pkg::*;
#(
  parameter int WIDTH  = entry_width(64, mod_width(64)),
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/rx_pkt_fifo.sv
// Packet-aware store-and-forward RX FIFO with first-word-fall-through output.
// Optional packet/drop statistics counters are enabled by RX_PKT_STAT_EN.
module rx_pkt_fifo
  import rx_fifo_pkg::*;
#(
  parameter int DATA_W       = 64,
  parameter int ADDR_W       = 9,
  parameter int MOD_W        = mod_width(DATA_W),
  parameter int AFULL_MARGIN = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] rxdata_i,
  input  logic              rxdata_sop_n_i,
  input  logic              rxdata_eop_n_i,
  input  logic [MOD_W-1:0]  rxdata_mod_i,
  input  logic              rx_src_rdy_n_i,
  output logic              fifo_full,
  output logic [DATA_W-1:0] rxdata_o,
  output logic              rxdata_sop_o,
  output logic              rxdata_eop_o,
  output logic [MOD_W-1:0]  rxdata_mod_o,
  output logic              rxdata_valid_o,
  input  logic              rx_fifo_rden,
  output logic              fifo_empty,
`ifdef RX_PKT_STAT_EN
  output logic [31:0]       pkt_cnt_o,
  output logic [15:0]       drop_cnt_o,
`endif
  output logic              pkt_drop_o
);

  localparam int ENTRY_W = entry_width(DATA_W, MOD_W);
  localparam int EOP_B   = eop_pos(DATA_W);
  localparam int SOP_B   = sop_pos(DATA_W);
  localparam int MOD_L   = mod_lsb(DATA_W);

  localparam logic [ADDR_W:0] DEPTH_P  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] AFULL_P  = (ADDR_W+1)'(AFULL_MARGIN);

  wr_state_t         state, state_nxt;
  logic [ADDR_W:0]   wr_ptr, cm_ptr, rd_ptr, fe_ptr;
  logic [ADDR_W:0]   wr_nxt, cm_nxt;
  logic [ADDR_W:0]   free_wr, free_cm;
  logic [ADDR_W-1:0] waddr;
  logic              we, drop;
  logic              beat, sop, eop;

  logic              avail, out_take, p2_load, rd_en;
  logic              vld_p1, vld_p2;
  logic [ENTRY_W-1:0] ram_q_p1;
  logic [DATA_W-1:0] data_p2;
  logic              sop_p2, eop_p2;
  logic [MOD_W-1:0]  mod_p2;

  assign beat = ~rx_src_rdy_n_i;
  assign sop  = ~rxdata_sop_n_i;
  assign eop  = ~rxdata_eop_n_i;

  // rd_ptr only moves when the user takes a beat, so prefetched beats still occupy space
  assign free_wr = DEPTH_P - (wr_ptr - rd_ptr);
  assign free_cm = DEPTH_P - (cm_ptr - rd_ptr);

  always_comb begin
    state_nxt = state;
    wr_nxt    = wr_ptr;
    cm_nxt    = cm_ptr;
    we        = 1'b0;
    waddr     = wr_ptr[ADDR_W-1:0];
    drop      = 1'b0;
    if (beat) begin
      if (state == DROP) begin
        if (eop) state_nxt = IDLE;
      end else if (state == PKT && !sop) begin
        if (free_wr == '0) begin
          drop      = 1'b1;
          wr_nxt    = cm_ptr;
          state_nxt = eop ? IDLE : DROP;
        end else begin
          we     = 1'b1;
          wr_nxt = wr_ptr + PTR_ONE;
          if (eop) begin
            cm_nxt    = wr_ptr + PTR_ONE;
            state_nxt = IDLE;
          end
        end
      end else begin
        // Packet start from IDLE, or a sop that truncates the packet in progress
        wr_nxt = cm_ptr;
        waddr  = cm_ptr[ADDR_W-1:0];
        if (state == PKT) drop = 1'b1;
        if (!sop) begin
          drop      = 1'b1;
          state_nxt = IDLE;
        end else if (free_cm == '0) begin
          drop      = 1'b1;
          state_nxt = eop ? IDLE : DROP;
        end else begin
          we     = 1'b1;
          wr_nxt = cm_ptr + PTR_ONE;
          if (eop) begin
            cm_nxt    = cm_ptr + PTR_ONE;
            state_nxt = IDLE;
          end else begin
            state_nxt = PKT;
          end
        end
      end
    end
  end

  assign avail    = (fe_ptr != cm_ptr);
  assign out_take = vld_p2 & rx_fifo_rden;
  assign p2_load  = vld_p1 & (~vld_p2 | out_take);
  assign rd_en    = avail & (~vld_p1 | p2_load);

  rx_pkt_fifo_ram #(
    .WIDTH  (ENTRY_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata ({rxdata_mod_i, sop, eop, rxdata_i}),
    .re    (rd_en),
    .raddr (fe_ptr[ADDR_W-1:0]),
    .rdata (ram_q_p1)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      cm_ptr     <= '0;
      rd_ptr     <= '0;
      fe_ptr     <= '0;
      vld_p1     <= 1'b0;
      vld_p2     <= 1'b0;
      pkt_drop_o <= 1'b0;
      fifo_full  <= 1'b0;
    end else begin
      state      <= state_nxt;
      wr_ptr     <= wr_nxt;
      cm_ptr     <= cm_nxt;
      pkt_drop_o <= drop;
      fifo_full  <= (free_wr <= AFULL_P);
      if (rd_en)    fe_ptr <= fe_ptr + PTR_ONE;
      if (out_take) rd_ptr <= rd_ptr + PTR_ONE;
      if (rd_en)        vld_p1 <= 1'b1;
      else if (p2_load) vld_p1 <= 1'b0;
      if (p2_load)       vld_p2 <= 1'b1;
      else if (out_take) vld_p2 <= 1'b0;
    end
  end

  // Output stage p2: loaded from the RAM read register, holds while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      data_p2 <= '0;
      sop_p2  <= 1'b0;
      eop_p2  <= 1'b0;
      mod_p2  <= '0;
    end else if (p2_load) begin
      data_p2 <= ram_q_p1[DATA_W-1:0];
      sop_p2  <= ram_q_p1[SOP_B];
      eop_p2  <= ram_q_p1[EOP_B];
      mod_p2  <= ram_q_p1[MOD_L +: MOD_W];
    end
  end

  assign rxdata_o       = data_p2;
  assign rxdata_sop_o   = sop_p2;
  assign rxdata_eop_o   = eop_p2;
  assign rxdata_mod_o   = mod_p2;
  assign rxdata_valid_o = vld_p2;
  assign fifo_empty     = ~avail & ~vld_p1 & ~vld_p2;

`ifdef RX_PKT_STAT_EN
  logic [31:0] pkt_cnt;
  logic [15:0] drop_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (cm_nxt != cm_ptr && pkt_cnt != '1) pkt_cnt  <= pkt_cnt + 32'd1;
      if (drop && drop_cnt != '1)            drop_cnt <= drop_cnt + 16'd1;
    end
  end

  assign pkt_cnt_o  = pkt_cnt;
  assign drop_cnt_o = drop_cnt;
`endif

endmodule
